// File: rtl/mult_bus_pkg.sv
// Shared definitions for the shift-add multiplier bus master:
// FSM state codes, multiplier func codes and fixed phase lengths.
package mult_bus_pkg;

    // FSM state encoding, kept as plain constants for legacy tools.
    typedef logic [3:0] state_t;
    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_WR_M      = 4'd1;
    localparam state_t ST_WR_Q      = 4'd2;
    localparam state_t ST_GAP       = 4'd3;
    localparam state_t ST_START     = 4'd4;
    localparam state_t ST_WAIT_BUSY = 4'd5;
    localparam state_t ST_WAIT_DONE = 4'd6;
    localparam state_t ST_RD_LO     = 4'd7;
    localparam state_t ST_RD_HI     = 4'd8;
    localparam state_t ST_DONE      = 4'd9;

    // Multiplier func pin codes. FUNC_RD_LO doubles as the harmless idle code.
    typedef enum logic [1:0] {
        FUNC_LD_M  = 2'b00,
        FUNC_LD_Q  = 2'b01,
        FUNC_RD_LO = 2'b10,
        FUNC_RD_HI = 2'b11
    } func_t;

    // Bus cycles spent on each register write and each product read.
    localparam int WR_CYCLES = 2;
    localparam int RD_CYCLES = 2;

    // Larger of two integers, used to size the shared cycle timer.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mult_bus_master_cycle_timer.sv
// Loadable down-counter with a done flag. Loading value V makes done
// assert on the (V+1)-th cycle after the load edge, so a state that loads
// len-1 on entry and leaves on done lasts exactly len cycles.
module cycle_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] cnt;

    // Count down from the loaded value and park at zero.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the clock edge.
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/mult_bus_master.sv
// Bus master for the shift-add multiplier: takes an operand pair, writes
// M and Q over the shared bus, presses start, waits for completion, reads
// the product back and offers it on a valid/ready result port.
// Optional build macro: MULT_SELFCHECK_EN adds a check_fail output that
// flags a read-back product differing from a locally computed a*b.
module mult_bus_master
    import mult_bus_pkg::*;
#(
    parameter int n          = 8,
    parameter int START_HOLD = 3330,
    parameter int TIMEOUT    = 65535
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           op_valid,
    output logic           op_ready,
    input  logic [n-1:0]   op_a,
    input  logic [n-1:0]   op_b,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*n-1:0] res_p,
    output logic           res_err,
    output logic           start_n,
    output logic [1:0]     func,
    output logic           oe,
    input  logic           mul_ready,
    input  logic [n-1:0]   bus_in,
    output logic [n-1:0]   bus_out,
    output logic           bus_drive
`ifdef MULT_SELFCHECK_EN
    ,
    output logic           check_fail
`endif
);

    localparam int TW = $clog2(max2(max2(START_HOLD, TIMEOUT), WR_CYCLES) + 1);

    state_t         state, state_next;
    logic           armed;
    logic [n-1:0]   a_r, b_r;
    logic           tmr_load;
    logic [TW-1:0]  tmr_val;
    logic           tmr_done;
    logic           accept;
    logic           timed_out;

    cycle_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .value (tmr_val),
        .done  (tmr_done)
    );

    // Next-state logic and timer reloads on entry to each timed state.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        state_next = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        accept     = 1'b0;
        timed_out  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (armed && op_valid) begin
                    accept     = 1'b1;
                    state_next = ST_WR_M;
                    tmr_load   = 1'b1;
                    tmr_val    = TW'(WR_CYCLES - 1);
                end
            end
            ST_WR_M: begin
                if (tmr_done) begin
                    state_next = ST_WR_Q;
                    tmr_load   = 1'b1;
                    tmr_val    = TW'(WR_CYCLES - 1);
                end
            end
            ST_WR_Q: begin
                if (tmr_done) state_next = ST_GAP;
            end
            ST_GAP: begin
                state_next = ST_START;
                tmr_load   = 1'b1;
                tmr_val    = TW'(START_HOLD - 1);
            end
            ST_START: begin
                if (tmr_done) begin
                    state_next = ST_WAIT_BUSY;
                    tmr_load   = 1'b1;
                    tmr_val    = TW'(TIMEOUT - 1);
                end
            end
            ST_WAIT_BUSY: begin
                if (!mul_ready) begin
                    state_next = ST_WAIT_DONE;
                    tmr_load   = 1'b1;
                    tmr_val    = TW'(TIMEOUT - 1);
                end else if (tmr_done) begin
                    timed_out  = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (mul_ready) begin
                    state_next = ST_RD_LO;
                    tmr_load   = 1'b1;
                    tmr_val    = TW'(RD_CYCLES - 1);
                end else if (tmr_done) begin
                    timed_out  = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_RD_LO: begin
                if (tmr_done) begin
                    state_next = ST_RD_HI;
                    tmr_load   = 1'b1;
                    tmr_val    = TW'(RD_CYCLES - 1);
                end
            end
            ST_RD_HI: begin
                if (tmr_done) state_next = ST_DONE;
            end
            ST_DONE: begin
                if (res_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Pin decode from the current state; anything not listed shows the idle code.
    always_comb begin
        op_ready  = armed && (state == ST_IDLE);
        res_valid = (state == ST_DONE);
        start_n   = (state != ST_START);
        func      = FUNC_RD_LO;
        oe        = 1'b0;
        bus_out   = '0;
        bus_drive = 1'b0;
        case (state)
            ST_WR_M: begin
                func      = FUNC_LD_M;
                bus_out   = a_r;
                bus_drive = 1'b1;
            end
            ST_WR_Q: begin
                func      = FUNC_LD_Q;
                bus_out   = b_r;
                bus_drive = 1'b1;
            end
            ST_RD_LO: oe = 1'b1;
            ST_RD_HI: begin
                func = FUNC_RD_HI;
                oe   = 1'b1;
            end
            default: ;
        endcase
    end

    // State, operand capture and result registers; reset drops any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            armed   <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            res_p   <= '0;
            res_err <= 1'b0;
        end else begin
            state <= state_next;
            armed <= 1'b1;
            if (accept) begin
                a_r <= op_a;
                b_r <= op_b;
            end
            if (timed_out) begin
                res_err <= 1'b1;
                res_p   <= '0;
            end
            // Sample on the last read cycle so the multiplier's output has settled.
            if (state == ST_RD_LO && tmr_done) res_p[n-1:0]   <= bus_in;
            if (state == ST_RD_HI && tmr_done) res_p[2*n-1:n] <= bus_in;
            if (state == ST_DONE && res_ready) res_err <= 1'b0;
        end
    end

`ifdef MULT_SELFCHECK_EN
    logic [2*n-1:0] expect_p;

    // Reference product of the captured operands.
    always_ff @(posedge clk) begin
        if (reset) expect_p <= '0;
        else       expect_p <= {{n{1'b0}}, a_r} * {{n{1'b0}}, b_r};
    end

    // A timed-out result carries no product, so it is never flagged.
    assign check_fail = (state == ST_DONE) && !res_err && (res_p != expect_p);
`endif

endmodule

// File: doc/mult_bus_master.md
Name: mult_bus_master

Overview:
- Upstream/downstream driver for the shift-add multiplier's shared 8-bit bus port.
- Accepts an operand pair over a valid/ready handshake and writes M, then Q, over the bus.
- Generates a debounce-compatible start press, waits for the multiplier to finish, then reads back the low and high product bytes.
- Presents the 2n-bit product on a valid/ready result interface. Sits between the host logic and the multiplier's startPB/func/oe/ready/data pins.

Parameters:
- n, 8, operand width; product is 2n bits.
- START_HOLD, 3330, cycles start_n is held low; must exceed the multiplier's debounce count.
- TIMEOUT, 65535, max cycles spent in either wait state before error.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- op_valid  input  1  operand pair available
- op_ready  output  1  block can accept operands
- op_a  input  n  multiplicand (written as M)
- op_b  input  n  multiplier (written as Q)
- res_valid  output  1  product valid
- res_ready  input  1  consumer accepts product
- res_p  output  2n  product {high byte, low byte}
- res_err  output  1  timeout flag, qualified by res_valid
- start_n  output  1  to multiplier startPB, active-low
- func  output  2  to multiplier func
- oe  output  1  to multiplier oe
- mul_ready  input  1  from multiplier ready
- bus_in  input  n  bus sampled value
- bus_out  output  n  value this block drives
- bus_drive  output  1  tristate enable for bus_out; the top level ties the tristate

Behaviour:
- Reset values: op_ready=0, res_valid=0, res_p=0, res_err=0, start_n=1, func=2'b10, oe=0, bus_out=0, bus_drive=0. State IDLE.
  - op_ready goes to 1 on the first cycle after reset.
- Idle code: func=2'b10 with oe=0 and bus_drive=0. func 00/01 are never presented outside the write states, so M and Q are never corrupted.
- Invariant: bus_drive and oe are never 1 in the same cycle. At least one dead cycle (both 0) separates a write from a read.
- States:
  - IDLE: op_ready=1. On op_valid, capture op_a/op_b; go to WR_M.
  - WR_M: 2 cycles; bus_out=a, bus_drive=1, func=00.
  - WR_Q: 2 cycles; bus_out=b, bus_drive=1, func=01.
  - GAP: 1 cycle; func=10, bus_drive=0.
  - START: START_HOLD cycles with start_n=0, then start_n=1; go to WAIT_BUSY.
  - WAIT_BUSY: wait for mul_ready=0.
  - WAIT_DONE: wait for mul_ready=1.
  - RD_LO: func=10, oe=1 for 2 cycles; sample bus_in into res_p[n-1:0] on the second cycle.
  - RD_HI: func=11, oe=1 for 2 cycles; sample into res_p[2n-1:n] on the second cycle.
  - DONE: oe=0, func=10, res_valid=1. Hold res_p until res_ready; then res_valid=0 and go to IDLE.
- mul_ready already low on entry to WAIT_BUSY is legal: pass through in 1 cycle.
- Timeout: the counter resets on entry to each wait state. On reaching TIMEOUT in either wait state:
  - set res_err=1, res_p=0;
  - go straight to DONE with no read cycles.
  - res_err clears when the result is accepted.
- res_valid and op_ready are never 1 together. A new op_valid during DONE is not accepted until return to IDLE.
- Reset mid-operation (any state, including during START or a read): all outputs return to reset values next cycle and the captured operands are discarded. The multiplier is not notified.
- Fixed-path latency from op accept to res_valid, n=8: 2+2+1+START_HOLD+t_busy+t_done+2+2+1 cycles.

Optional Feature:
- MULT_SELFCHECK_EN defined: the block keeps a registered a*b computed with a combinational multiply from the captured operands.
  - Adds output port check_fail (1 bit, reset 0).
  - check_fail=1 in DONE when res_p differs from that product and res_err=0.
- MULT_SELFCHECK_EN undefined: no multiplier inferred and no check_fail port.

Decomposition:
- Package mult_bus_pkg: state enum; func codes FUNC_LD_M=2'b00, FUNC_LD_Q=2'b01, FUNC_RD_LO=2'b10, FUNC_RD_HI=2'b11; WR_CYCLES=2, RD_CYCLES=2.
- One sub-module, cycle_timer: loadable down-counter with done flag, used for the write, read, START_HOLD and TIMEOUT counts.

Test Plan:
- a=8'd13, b=8'd11 with the behavioural multiplier model → func sequence 00,00,01,01, then start_n low exactly START_HOLD cycles → res_valid, res_p=16'd143, res_err=0.
- a=8'hFF, b=8'hFF → res_p=16'hFE01; bus_drive and oe never 1 in the same cycle, and a dead cycle separates write and read.
- mul_ready held 1 forever (model never starts), TIMEOUT=100 → res_valid after 100 cycles in WAIT_BUSY, res_err=1, res_p=0.
- res_ready held 0 for 20 cycles in DONE while op_valid=1 → res_p stable, op_ready=0, no new func 00/01 issued; accepted on res_ready.
- reset asserted during START → next cycle start_n=1, func=10, oe=0, bus_drive=0; a following operation with a=3, b=5 gives 16'd15.
- MULT_SELFCHECK_EN defined, model corrupted to return +1 → check_fail=1 in DONE for a=2, b=2.
